// File: rtl/controlador_tiros_pkg.sv
// Shared types for the shot controller: record layout, direction codes,
// FSM states and the single-step movement rule.
package pkg_tiros;

    localparam int          N_SLOTS    = 16;
    localparam logic [3:0]  ULTIMO_IDX = 4'(N_SLOTS - 1);

    typedef enum logic [1:0] {
        CIMA     = 2'b00,   // row - 1
        DIREITA  = 2'b01,   // col + 1
        BAIXO    = 2'b10,   // row + 1
        ESQUERDA = 2'b11    // col - 1
    } direcao_t;

    typedef enum logic [1:0] {
        OCIOSO,
        VARRE,
        ESCREVE,
        FIM
    } estado_t;

    // Shot record as stored in RAM: [9:6] linha, [5:2] coluna, [1:0] direcao.
    typedef struct packed {
        logic [3:0] linha;
        logic [3:0] coluna;
        direcao_t   direcao;
    } tiro_t;

    typedef struct packed {
        logic  expira;
        tiro_t tiro;
    } passo_t;

    // Advance a shot by one cell. The bound is checked before the add or
    // subtract, so the 4-bit fields never wrap; an expired shot becomes all zeros.
    function automatic passo_t avanca_tiro(input tiro_t t,
                                           input logic [3:0] max_linha,
                                           input logic [3:0] max_coluna);
        passo_t p;
        p.expira = 1'b0;
        p.tiro   = t;
        case (t.direcao)
            CIMA: begin
                if (t.linha == 4'd0) p.expira = 1'b1;
                else                 p.tiro.linha = t.linha - 4'd1;
            end
            DIREITA: begin
                if (t.coluna >= max_coluna) p.expira = 1'b1;
                else                        p.tiro.coluna = t.coluna + 4'd1;
            end
            BAIXO: begin
                if (t.linha >= max_linha) p.expira = 1'b1;
                else                      p.tiro.linha = t.linha + 4'd1;
            end
            default: begin
                if (t.coluna == 4'd0) p.expira = 1'b1;
                else                  p.tiro.coluna = t.coluna - 4'd1;
            end
        endcase
        if (p.expira) p.tiro = '0;
        return p;
    endfunction

endpackage

// File: rtl/controlador_tiros_localizador.sv
// Priority encoder: lowest free (zero) slot of the active mask, plus full flag.
module localizador_slot_livre
    import pkg_tiros::*;
(
    input  logic [N_SLOTS-1:0] mascara,
    output logic [3:0]         slot_livre,
    output logic               cheio
);

    // Scan from the top down so the lowest zero wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a path that skips the assignment infers a latch.
        slot_livre = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!mascara[i]) slot_livre = 4'(i);
        end
        cheio = &mascara;
    end

endmodule

// File: rtl/controlador_tiros.sv
// Shot table controller: inserts shots into free slots and, on each frame
// tick, sweeps the table read-modify-write to move or expire every shot.
module controlador_tiros
    import pkg_tiros::*;
#(
    parameter int MAX_LINHA  = 15,
    parameter int MAX_COLUNA = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        disparar,
    input  logic [3:0]  tiro_linha,
    input  logic [3:0]  tiro_coluna,
    input  logic [1:0]  tiro_direcao,
    output logic [3:0]  mem_addr,
    output logic        mem_we,
    output logic [9:0]  mem_data,
    input  logic [9:0]  mem_q,
    output logic        pronto,
    output logic        fim_varredura,
    output logic        cheio,
    output logic [15:0] ativos,
    output logic [4:0]  num_ativos
);

    localparam logic [3:0] MAX_L = 4'(MAX_LINHA);
    localparam logic [3:0] MAX_C = 4'(MAX_COLUNA);

    estado_t              estado_q, estado_d;
    logic [3:0]           idx_q, idx_d;
    logic                 pendente_q, pendente_d;
    logic [N_SLOTS-1:0]   ativos_q, ativos_d;
    logic                 mem_we_q, mem_we_d;
    logic [3:0]           mem_addr_q, mem_addr_d;
    logic [9:0]           mem_data_q, mem_data_d;

    logic [3:0]           slot_livre;
    logic                 cheio_w;
    passo_t               passo;

    localizador_slot_livre u_localizador (
        .mascara    (ativos_q),
        .slot_livre (slot_livre),
        .cheio      (cheio_w)
    );

    // State and datapath registers.
    // NOTE: the shot RAM is never cleared on reset; validity lives only in ativos_q, so stale records are harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            estado_q   <= OCIOSO;
            idx_q      <= '0;
            pendente_q <= 1'b0;
            ativos_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            estado_q   <= estado_d;
            idx_q      <= idx_d;
            pendente_q <= pendente_d;
            ativos_q   <= ativos_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Next-state logic of the sweep FSM.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO: begin
                // A simultaneous insert defers the sweep by one cycle via pendente.
                if (pendente_q || (iniciar && !disparar)) estado_d = VARRE;
            end
            VARRE: begin
                if (ativos_q[idx_q])           estado_d = ESCREVE;
                else if (idx_q == ULTIMO_IDX)  estado_d = FIM;
            end
            ESCREVE: begin
                estado_d = (idx_q == ULTIMO_IDX) ? FIM : VARRE;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Datapath and memory-port control for each state.
    always_comb begin
        idx_d      = idx_q;
        pendente_d = pendente_q;
        ativos_d   = ativos_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        passo      = avanca_tiro(tiro_t'(mem_q), MAX_L, MAX_C);
        case (estado_q)
            OCIOSO: begin
                idx_d = '0;
                if (disparar && !cheio_w) begin
                    mem_we_d             = 1'b1;
                    mem_addr_d           = slot_livre;
                    mem_data_d           = {tiro_linha, tiro_coluna, tiro_direcao};
                    ativos_d[slot_livre] = 1'b1;
                end
                if (pendente_q)                pendente_d = 1'b0;
                else if (iniciar && disparar)  pendente_d = 1'b1;
            end
            VARRE: begin
                // The address register feeds the RAM, so data is back in ESCREVE.
                if (ativos_q[idx_q])           mem_addr_d = idx_q;
                else if (idx_q != ULTIMO_IDX)  idx_d = idx_q + 4'd1;
            end
            ESCREVE: begin
                mem_we_d   = 1'b1;
                mem_addr_d = idx_q;
                mem_data_d = passo.tiro;
                if (passo.expira)         ativos_d[idx_q] = 1'b0;
                if (idx_q != ULTIMO_IDX)  idx_d = idx_q + 4'd1;
            end
            default: ;
        endcase
    end

    // Status outputs decoded from the state and the active mask.
    always_comb begin
        pronto        = (estado_q == OCIOSO);
        fim_varredura = (estado_q == FIM);
        num_ativos    = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            num_ativos = num_ativos + 5'(ativos_q[i]);
        end
    end

    assign cheio    = cheio_w;
    assign ativos   = ativos_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_controlador_tiros.sv
// Directed bench for controlador_tiros with a RAM model and a write scoreboard.
module tb_controlador_tiros;

    logic        clk = 1'b0;
    logic        reset;
    logic        iniciar, disparar;
    logic [3:0]  tiro_linha, tiro_coluna;
    logic [1:0]  tiro_direcao;
    logic [3:0]  mem_addr;
    logic        mem_we;
    logic [9:0]  mem_data;
    logic [9:0]  mem_q;
    logic        pronto, fim_varredura, cheio;
    logic [15:0] ativos;
    logic [4:0]  num_ativos;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];     // expected writes {addr, data}
    logic [15:0] mdl_ativos;
    logic [9:0]  mdl_ram[16];
    logic [9:0]  tb_ram[16];   // shot RAM seen by the DUT

    controlador_tiros dut (
        .clk           (clk),
        .reset         (reset),
        .iniciar       (iniciar),
        .disparar      (disparar),
        .tiro_linha    (tiro_linha),
        .tiro_coluna   (tiro_coluna),
        .tiro_direcao  (tiro_direcao),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_data      (mem_data),
        .mem_q         (mem_q),
        .pronto        (pronto),
        .fim_varredura (fim_varredura),
        .cheio         (cheio),
        .ativos        (ativos),
        .num_ativos    (num_ativos)
    );

    always #5 clk = ~clk;

    // RAM: write on the edge, read straight from the registered address.
    always @(posedge clk) if (mem_we) tb_ram[mem_addr] <= mem_data;
    assign mem_q = tb_ram[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample at the falling edge and score any write.
    task automatic cycle();
        logic [13:0] e;
        @(posedge clk);
        @(negedge clk);
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check("escrita_inesperada", 32'(mem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("escrita", 32'({mem_addr, mem_data}), 32'(e));
            end
        end
    endtask

    function automatic logic [10:0] modelo_passo(input logic [9:0] r);
        logic [3:0] l, c;
        l = r[9:6];
        c = r[5:2];
        case (r[1:0])
            2'b00:   return (l == 4'd0)  ? 11'h400 : {1'b0, l - 4'd1, c, r[1:0]};
            2'b01:   return (c == 4'd15) ? 11'h400 : {1'b0, l, c + 4'd1, r[1:0]};
            2'b10:   return (l == 4'd15) ? 11'h400 : {1'b0, l + 4'd1, c, r[1:0]};
            default: return (c == 4'd0)  ? 11'h400 : {1'b0, l, c - 4'd1, r[1:0]};
        endcase
    endfunction

    task automatic modelo_insere(input logic [3:0] l, input logic [3:0] c, input logic [1:0] d);
        int livre;
        livre = -1;
        for (int i = 15; i >= 0; i--) if (!mdl_ativos[i]) livre = i;
        if (livre >= 0) begin
            exp_q.push_back({4'(livre), l, c, d});
            mdl_ativos[livre] = 1'b1;
            mdl_ram[livre]    = {l, c, d};
        end
    endtask

    // Returns the expected sweep latency for the current model contents.
    task automatic modelo_varre(output int lat);
        logic [10:0] p;
        lat = 1;
        for (int i = 0; i < 16; i++) begin
            if (mdl_ativos[i]) begin
                p = modelo_passo(mdl_ram[i]);
                exp_q.push_back({4'(i), p[9:0]});
                mdl_ram[i] = p[9:0];
                if (p[10]) mdl_ativos[i] = 1'b0;
                lat += 2;
            end else begin
                lat += 1;
            end
        end
    endtask

    task automatic shoot(input logic [3:0] l, input logic [3:0] c, input logic [1:0] d);
        modelo_insere(l, c, d);
        disparar = 1'b1; tiro_linha = l; tiro_coluna = c; tiro_direcao = d;
        cycle();
        disparar = 1'b0;
        cycle();
    endtask

    // Start a sweep (optionally with a simultaneous insert) and time fim_varredura.
    task automatic sweep(input logic com_disparo, input logic [3:0] l, input logic [3:0] c,
                         input logic [1:0] d, output int lat, output int lat_mdl);
        if (com_disparo) modelo_insere(l, c, d);
        modelo_varre(lat_mdl);
        iniciar = 1'b1; disparar = com_disparo;
        tiro_linha = l; tiro_coluna = c; tiro_direcao = d;
        cycle();
        iniciar = 1'b0; disparar = 1'b0;
        lat = 1;
        while (!fim_varredura && lat < 100) begin
            cycle();
            lat++;
        end
        check("fim_alcancado", 32'(fim_varredura), 32'd1);
        cycle();
        check("fim_um_ciclo", 32'(fim_varredura), 32'd0);
        check("pronto_apos_fim", 32'(pronto), 32'd1);
        check("ativos_apos_varredura", 32'(ativos), 32'(mdl_ativos));
        check("fila_vazia", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        exp_q.delete();
        mdl_ativos = '0;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_ativos", 32'(ativos), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd1);
        check("rst_fim", 32'(fim_varredura), 32'd0);
        cycle();
        check("rst_fim_mantido", 32'(fim_varredura), 32'd0);
        reset = 1'b0;
        cycle();
    endtask

    initial begin
        int lat, lat_mdl, antes;
        logic [15:0] mascara;
        reset = 1'b1; iniciar = 1'b0; disparar = 1'b0;
        tiro_linha = '0; tiro_coluna = '0; tiro_direcao = '0;
        mdl_ativos = '0;
        cycle();
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_data", 32'(mem_data), 32'd0);
        check("reset_we", 32'(mem_we), 32'd0);
        check("reset_num", 32'(num_ativos), 32'd0);
        check("reset_cheio", 32'(cheio), 32'd0);
        check("reset_pronto", 32'(pronto), 32'd1);
        reset = 1'b0;
        cycle();

        // 1: first shot goes to slot 0
        modelo_insere(4'd5, 4'd7, 2'b01);
        disparar = 1'b1; tiro_linha = 4'd5; tiro_coluna = 4'd7; tiro_direcao = 2'b01;
        cycle();
        disparar = 1'b0;
        check("t1_we", 32'(mem_we), 32'd1);
        check("t1_ativos", 32'(ativos), 32'h0001);
        check("t1_num", 32'(num_ativos), 32'd1);
        cycle();

        // 2: one active slot -> 18-cycle sweep, slot 0 moves right
        sweep(1'b0, 4'd0, 4'd0, 2'b00, lat, lat_mdl);
        check("t2_latencia", 32'(lat), 32'd18);
        check("t2_ram0", 32'(tb_ram[0]), 32'b0101_1000_01);

        // 3: expiry in every direction, slot 3 exits through the top
        shoot(4'd3, 4'd15, 2'b01);
        shoot(4'd9, 4'd0, 2'b11);
        shoot(4'd0, 4'd4, 2'b00);
        antes = int'(num_ativos);
        sweep(1'b0, 4'd0, 4'd0, 2'b00, lat, lat_mdl);
        check("t3_latencia", 32'(lat), 32'(lat_mdl));
        check("t3_ram3", 32'(tb_ram[3]), 32'd0);
        check("t3_ativo3", 32'(ativos[3]), 32'd0);
        check("t3_num", 32'(num_ativos), 32'(antes - 3));

        // moves without expiry, plus the bottom edge
        shoot(4'd15, 4'd2, 2'b10);
        shoot(4'd4, 4'd4, 2'b00);
        shoot(4'd6, 4'd6, 2'b11);
        shoot(4'd2, 4'd3, 2'b10);
        sweep(1'b0, 4'd0, 4'd0, 2'b00, lat, lat_mdl);
        check("t3b_latencia", 32'(lat), 32'(lat_mdl));
        check("t3b_ram4", 32'(tb_ram[4]), 32'({4'd3, 4'd3, 2'b10}));

        // 4: fill the table, then a 17th shot is dropped
        while (mdl_ativos != 16'hFFFF)
            shoot(4'($urandom_range(1, 14)), 4'($urandom_range(1, 14)), 2'($urandom_range(0, 3)));
        check("t4_cheio", 32'(cheio), 32'd1);
        check("t4_ativos", 32'(ativos), 32'hFFFF);
        check("t4_num", 32'(num_ativos), 32'd16);
        mascara = ativos;
        shoot(4'd1, 4'd1, 2'b01);
        check("t4_sem_mudanca", 32'(ativos), 32'(mascara));
        sweep(1'b0, 4'd0, 4'd0, 2'b00, lat, lat_mdl);
        check("t4_latencia_max", 32'(lat), 32'd33);

        // 5: iniciar together with disparar
        do_reset();
        sweep(1'b1, 4'd2, 4'd2, 2'b10, lat, lat_mdl);
        check("t5_ram0", 32'(tb_ram[0]), 32'({4'd3, 4'd2, 2'b10}));
        check("t5_ativos", 32'(ativos), 32'h0001);

        // 6: reset while in ESCREVE
        do_reset();
        shoot(4'd1, 4'd1, 2'b01);
        iniciar = 1'b1;
        cycle();
        iniciar = 1'b0;
        cycle();
        check("t6_ocupado", 32'(pronto), 32'd0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t6_sem_fim", 32'(fim_varredura), 32'd0);
        end
        check("t6_num", 32'(num_ativos), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_tiros.md
Name: controlador_tiros

Overview:
- Owns the 16-entry x 10-bit shot table RAM: 1 write port; read data valid one cycle after the address is presented, because the address is registered.
- Inserts new shots into free slots.
- On each frame tick, sweeps the table read-modify-write: advances every active shot one cell and expires shots that leave the field.
- Sits between the game FSM (disparar/iniciar) and the shot memory. It is the only writer of that memory.

Parameters:
- MAX_LINHA, 15, largest valid row index (4-bit field).
- MAX_COLUNA, 15, largest valid column index (4-bit field).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset: asynchronous, active-high.
- iniciar  in  1  1-cycle pulse: start one sweep.
- disparar  in  1  1-cycle pulse: insert a shot.
- tiro_linha  in  4  row of the new shot.
- tiro_coluna  in  4  column of the new shot.
- tiro_direcao  in  2  direction of the new shot.
- mem_addr  out  4  shot-memory address.
- mem_we  out  1  shot-memory write enable.
- mem_data  out  10  shot-memory write data.
- mem_q  in  10  shot-memory read data, valid the cycle after mem_addr.
- pronto  out  1  high in OCIOSO.
- fim_varredura  out  1  1-cycle pulse when a sweep completes.
- cheio  out  1  all 16 slots active.
- ativos  out  16  active-slot mask, bit i = slot i.
- num_ativos  out  5  popcount of ativos.

Behaviour:
- Record format:
  - [9:6] linha.
  - [5:2] coluna.
  - [1:0] direcao: 00 cima (row-1), 01 direita (col+1), 10 baixo (row+1), 11 esquerda (col-1).
- Slot validity is held only in ativos, never in the RAM.
- Reset (async, immediate):
  - state OCIOSO.
  - ativos=0, num_ativos=0, cheio=0.
  - mem_we=0, mem_addr=0, mem_data=0.
  - fim_varredura=0, pronto=1.
  - pendente (latched iniciar) = 0.
  - RAM contents are not cleared; any partial write is harmless because ativos=0.
- States:
  - OCIOSO:
    - disparar with cheio=0: mem_we=1, mem_addr=lowest free slot, mem_data={tiro_linha,tiro_coluna,tiro_direcao}. Set that ativos bit at the same edge. Stay in OCIOSO.
    - disparar with cheio=1: ignored, no write.
    - iniciar: go to VARRE with idx=0.
    - iniciar and disparar in the same cycle: insertion happens that cycle, iniciar is latched in pendente, and VARRE starts next cycle. The sweep includes the new shot.
  - VARRE (idx 0..15):
    - ativos[idx]=0: idx++ (1 cycle per slot).
    - ativos[idx]=1: drive mem_addr=idx, mem_we=0, go to ESCREVE.
    - After idx=15 has been handled: go to FIM.
  - ESCREVE:
    - mem_q is valid this cycle. Compute the next position from direcao.
    - Decrementing from 0, or incrementing past MAX_LINHA/MAX_COLUNA, expires the shot: write 10'b0 and clear ativos[idx].
    - Otherwise write the updated record with direcao unchanged.
    - mem_we=1, mem_addr=idx, then idx++ and return to VARRE, or go to FIM if idx was 15.
  - FIM: fim_varredura=1 for exactly one cycle, then OCIOSO.
- disparar and iniciar outside OCIOSO are ignored, except for the pendente case above; pronto tells the caller when it may retry.
- Sweep latency: 1 cycle per inactive slot + 2 per active slot + 1 (FIM). Range 17–33 cycles.
- num_ativos and cheio are derived combinationally from ativos. An insertion and an expiry never coincide, because insertion happens only in OCIOSO.
- Arithmetic: 4-bit unsigned. The bound check happens before the add/subtract, so there is no wrap-around.

Decomposition:
- Package pkg_tiros:
  - field slices LINHA, COLUNA, DIRECAO.
  - direction codes CIMA, DIREITA, BAIXO, ESQUERDA.
  - FSM state enum.
  - N_SLOTS=16.
- Sub-module localizador_slot_livre: 16-bit mask in -> 4-bit lowest-zero index + cheio flag (priority encoder).

Test Plan:
1. After reset, disparar with linha=5, coluna=7, dir=01 -> next edge: mem_we=1, addr=0, data=0101_0111_01; ativos=16'h0001; num_ativos=1.
2. From state 1, iniciar -> VARRE reads addr 0; ESCREVE writes 0101_1000_01 to addr 0; fim_varredura pulses 18 cycles after iniciar.
3. Shot at linha=0, dir=00 in slot 3, sweep -> slot 3 written 10'b0; ativos[3]=0; num_ativos decremented by 1.
4. 16 disparos -> cheio=1, ativos=16'hFFFF; 17th disparar -> no mem_we and masks unchanged.
5. iniciar and disparar in the same OCIOSO cycle -> insertion into slot 0 that cycle; sweep starts the next cycle and updates slot 0.
6. reset asserted during ESCREVE -> mem_we drops immediately (async); ativos=0, pronto=1, and no fim_varredura pulse.
